// File: rtl/uart_rx_stream_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_stream_pkg
// Shared UART definitions used by the receiver (and by the transmitter):
//   parity_t    - parity mode selection
//   rx_state_t  - receiver FSM state encoding, also exported as a debug port
//   parity_bit  - parity bit value a transmitter appends for a given data byte
//   frame_bits  - total bit times of one frame (start + data + parity + stop)
// -----------------------------------------------------------------------------
package uart_rx_stream_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // EVEN: data ^ parity == 0; ODD: data ^ parity == 1. Unused data bits must be 0.
    function automatic logic parity_bit(input logic [7:0] data, input parity_t parity);
        case (parity)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int frame_bits(input int bytesize, input parity_t parity, input int stopsize);
        return 1 + bytesize + ((parity != PAR_NONE) ? 1 : 0) + stopsize;
    endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// -----------------------------------------------------------------------------
// uart_rx_stream_if
// Received-byte stream.
//   str_tvalid - byte available (producer)
//   str_tdata  - byte value (producer)
//   str_tready - consumer accepts byte
// Handshake: a byte transfers on every clock edge where str_tvalid && str_tready.
// While str_tvalid is high and str_tready low, str_tdata is held stable and
// str_tvalid is not withdrawn.
// -----------------------------------------------------------------------------
interface uart_rx_stream_if;
    logic       str_tvalid;
    logic [7:0] str_tdata;
    logic       str_tready;

    modport master (output str_tvalid, output str_tdata, input str_tready);
    modport slave  (input str_tvalid, input str_tdata, output str_tready);
endinterface

// File: rtl/uart_rx_stream_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for an asynchronous single-bit input.
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset; both flops load RST_VAL
//   i_d     - asynchronous input
//   o_q     - synchronized output (2 cycles latency)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_stream.sv
// -----------------------------------------------------------------------------
// uart_rx_stream
// UART receiver: oversamples uart_rxd, deframes start/data/parity/stop bits and
// delivers each good byte on a valid/ready stream.
//   clk          - clock
//   rst_n        - synchronous active-low reset
//   uart_rxd     - asynchronous serial input, idle high
//   str          - byte stream (master side)
//   err_frame    - one-cycle pulse: a stop bit sampled low
//   err_parity   - one-cycle pulse: parity mismatch
//   err_overrun  - one-cycle pulse: byte completed while previous still held
//   o_dbg_state  - current FSM state
// -----------------------------------------------------------------------------
module uart_rx_stream
    import uart_rx_stream_pkg::*;
#(
    parameter int      BYTESIZE = 8,
    parameter parity_t PARITY   = PAR_NONE,
    parameter int      STOPSIZE = 1,
    parameter int      N_BIT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rxd,
    uart_rx_stream_if.master      str,
    output logic                  err_frame,
    output logic                  err_parity,
    output logic                  err_overrun,
    output rx_state_t             o_dbg_state
);
    localparam int CW = $clog2(N_BIT);
    localparam int BW = $clog2(BYTESIZE + STOPSIZE + 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(N_BIT / 2 - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(N_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(BYTESIZE - 1);
    // The bit counter keeps running through the stop bits after the data bits.
    localparam logic [BW-1:0] STOP_LAST = BW'(BYTESIZE + STOPSIZE - 1);

    logic                w_rxd_s;
    rx_state_t           r_state;
    rx_state_t           w_next;
    logic                r_rxd_prev;
    logic [CW-1:0]       r_baud;
    logic [BW-1:0]       r_bit;
    logic [BYTESIZE-1:0] r_shift;
    logic                r_par_err;
    logic                r_stop_err;
    logic                r_tvalid;
    logic [7:0]          r_tdata;
    logic                r_err_frame;
    logic                r_err_parity;
    logic                r_err_overrun;

    logic       w_tick;
    logic       w_fall;
    logic       w_stop_bad;
    logic       w_hs;
    logic [7:0] w_data8;
    logic       w_smp_data;
    logic       w_smp_par;
    logic       w_smp_stop;
    logic       w_done;
    logic       w_frame;
    logic       w_par_bad;
    logic       w_good;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (uart_rxd),
        .o_q     (w_rxd_s)
    );

    assign w_tick     = (r_baud == BAUD_MID);
    // Only a high-to-low transition starts a frame, never a line already low.
    assign w_fall     = r_rxd_prev & ~w_rxd_s;
    assign w_stop_bad = r_stop_err | ~w_rxd_s;
    assign w_hs       = r_tvalid & str.str_tready;
    assign w_data8    = 8'(r_shift);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START:  if (w_tick) w_next = w_rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_tick && (r_bit == DATA_LAST))
                           w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            // Leave at mid of the last stop bit so the next start edge is caught early.
            ST_STOP:   if (w_tick && (r_bit == STOP_LAST))
                           w_next = w_stop_bad ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (w_rxd_s) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        w_smp_data = 1'b0;
        w_smp_par  = 1'b0;
        w_smp_stop = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_DATA:   w_smp_data = w_tick;
            ST_PARITY: w_smp_par  = w_tick;
            ST_STOP: begin
                w_smp_stop = w_tick;
                w_done     = w_tick && (r_bit == STOP_LAST);
            end
            default: ;
        endcase
        // Frame error dominates parity, parity dominates delivery/overrun.
        w_frame   = w_done & w_stop_bad;
        w_par_bad = w_done & ~w_stop_bad & r_par_err;
        w_good    = w_done & ~w_stop_bad & ~r_par_err;
    end

    // Counters, shift register, error capture and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxd_prev    <= 1'b1;
            r_baud        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_par_err     <= 1'b0;
            r_stop_err    <= 1'b0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_err_frame   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_rxd_prev <= w_rxd_s;

            // Held at 0 while waiting, so START begins counting from the edge.
            if (r_state == ST_IDLE || r_state == ST_BREAK) r_baud <= '0;
            else if (r_baud == BAUD_LAST)                  r_baud <= '0;
            else                                           r_baud <= r_baud + 1'b1;

            if (r_state == ST_IDLE)         r_bit <= '0;
            else if (w_smp_data | w_smp_stop) r_bit <= r_bit + 1'b1;

            // LSB arrives first, so shifting in at the MSB leaves bit 0 in place.
            if (w_smp_data) r_shift <= {w_rxd_s, r_shift[BYTESIZE-1:1]};

            if (r_state == ST_IDLE) r_par_err <= 1'b0;
            else if (w_smp_par)     r_par_err <= (parity_bit(w_data8, PARITY) != w_rxd_s);

            if (r_state == ST_IDLE)          r_stop_err <= 1'b0;
            else if (w_smp_stop && !w_rxd_s) r_stop_err <= 1'b1;

            r_err_frame   <= w_frame;
            r_err_parity  <= w_par_bad;
            r_err_overrun <= w_good & r_tvalid & ~str.str_tready;

            // A completion coinciding with a handshake reloads without a gap.
            if (w_good && (!r_tvalid || w_hs)) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_data8;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign str.str_tvalid = r_tvalid;
    assign str.str_tdata  = r_tdata;
    assign err_frame      = r_err_frame;
    assign err_parity     = r_err_parity;
    assign err_overrun    = r_err_overrun;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_uart_rx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_stream
// Two receivers (8N1 and 8E1, N_BIT=4) driven by a bit-level serial driver.
// Expected bytes and error counts come from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_stream;
    import uart_rx_stream_pkg::*;

    localparam int NB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd0  = 1'b1;
    logic rxd1  = 1'b1;

    uart_rx_stream_if if0 ();
    uart_rx_stream_if if1 ();

    logic      ef0, ep0, eo0, ef1, ep1, eo1;
    rx_state_t st0, st1;

    uart_rx_stream #(.BYTESIZE(8), .PARITY(PAR_NONE), .STOPSIZE(1), .N_BIT(NB)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd0), .str(if0.master),
        .err_frame(ef0), .err_parity(ep0), .err_overrun(eo0), .o_dbg_state(st0)
    );

    uart_rx_stream #(.BYTESIZE(8), .PARITY(PAR_EVEN), .STOPSIZE(1), .N_BIT(NB)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd1), .str(if1.master),
        .err_frame(ef1), .err_parity(ep1), .err_overrun(eo1), .o_dbg_state(st1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int exp_f[2], exp_p[2], exp_o[2];
    int act_f[2], act_p[2], act_o[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_errs(input int sel, input string tag);
        check({tag, "_err_frame_cnt"},   act_f[sel], exp_f[sel]);
        check({tag, "_err_parity_cnt"},  act_p[sel], exp_p[sel]);
        check({tag, "_err_overrun_cnt"}, act_o[sel], exp_o[sel]);
    endtask

    // Reference model: frame outcome from the framing rules.
    // holding = a previous byte is still unaccepted when this frame completes.
    task automatic model_frame(input int sel, input logic [7:0] d, input bit par_good,
                               input bit stop_good, input bit holding);
        if (!stop_good)     exp_f[sel]++;
        else if (!par_good) exp_p[sel]++;
        else if (holding)   exp_o[sel]++;
        else if (sel == 0)  exp_q0.push_back(d);
        else                exp_q1.push_back(d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (if0.str_tvalid && if0.str_tready) begin
                if (exp_q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dut0_byte: got %02h expected none", if0.str_tdata);
                end else begin
                    e = exp_q0.pop_front();
                    check("dut0_byte", 32'(if0.str_tdata), 32'(e));
                end
            end
            if (if1.str_tvalid && if1.str_tready) begin
                if (exp_q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dut1_byte: got %02h expected none", if1.str_tdata);
                end else begin
                    e = exp_q1.pop_front();
                    check("dut1_byte", 32'(if1.str_tdata), 32'(e));
                end
            end
            if (ef0) act_f[0]++;
            if (ep0) act_p[0]++;
            if (eo0) act_o[0]++;
            if (ef1) act_f[1]++;
            if (ep1) act_p[1]++;
            if (eo1) act_o[1]++;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rxd0 = b;
        else          rxd1 = b;
        repeat (NB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                              input bit par_v, input bit stop_v, input int extra_low);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par_v);
        drive_bit(sel, stop_v);
        for (int i = 0; i < extra_low; i++) drive_bit(sel, 1'b0);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    function automatic bit even_par(input logic [7:0] d);
        return bit'($countones(d) % 2);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        int         sel;
        bit         pg, sg;
        int         xl;
        for (int i = 0; i < 2; i++) begin
            exp_f[i] = 0; exp_p[i] = 0; exp_o[i] = 0;
            act_f[i] = 0; act_p[i] = 0; act_o[i] = 0;
        end
        if0.str_tready = 1'b1;
        if1.str_tready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid",  32'(if0.str_tvalid), 32'd0);
        check("reset_tdata",   32'(if0.str_tdata), 32'd0);
        check("reset_errs",    32'({ef0, ep0, eo0, ef1, ep1, eo1}), 32'd0);
        check("reset_state",   32'(st0), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5
        model_frame(0, 8'hA5, 1, 1, 0);
        send_frame(0, 8'hA5, 0, 0, 1, 0);
        check_errs(0, "a5");

        // One-clock low glitch on idle line
        rxd0 = 1'b0;
        @(posedge clk); #1;
        rxd0 = 1'b1;
        repeat (12) @(posedge clk); #1;
        check("glitch_state",  32'(st0), 32'(ST_IDLE));
        check("glitch_tvalid", 32'(if0.str_tvalid), 32'd0);
        check_errs(0, "glitch");

        // Stop bit low, line low 3 bits, then a good frame
        model_frame(0, 8'h3C, 1, 0, 0);
        send_frame(0, 8'h3C, 0, 0, 0, 2);
        check_errs(0, "frame");
        model_frame(0, 8'h5A, 1, 1, 0);
        send_frame(0, 8'h5A, 0, 0, 1, 0);
        check_errs(0, "after_frame");

        // EVEN parity: good then bad
        model_frame(1, 8'h03, 1, 1, 0);
        send_frame(1, 8'h03, 1, 1'b0, 1, 0);
        model_frame(1, 8'h03, 0, 1, 0);
        send_frame(1, 8'h03, 1, 1'b1, 1, 0);
        check_errs(1, "parity");

        // Overrun
        if0.str_tready = 1'b0;
        model_frame(0, 8'h11, 1, 1, 0);
        send_frame(0, 8'h11, 0, 0, 1, 0);
        model_frame(0, 8'h22, 1, 1, 1);
        send_frame(0, 8'h22, 0, 0, 1, 0);
        check("ovr_tvalid", 32'(if0.str_tvalid), 32'd1);
        check("ovr_tdata",  32'(if0.str_tdata), 32'h11);
        check_errs(0, "overrun");
        if0.str_tready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("ovr_drop_tvalid", 32'(if0.str_tvalid), 32'd0);
        check("ovr_queue_empty", 32'(exp_q0.size()), 32'd0);

        // Reset in the middle of the data bits of 0x77
        drive_bit(0, 1'b0);
        d = 8'h77;
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_mid_tvalid", 32'(if0.str_tvalid), 32'd0);
        check("rst_mid_errs",   32'({ef0, ep0, eo0}), 32'd0);
        check("rst_mid_state",  32'(st0), 32'(ST_IDLE));
        rxd0  = 1'b1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk); #1;
        model_frame(0, 8'h81, 1, 1, 0);
        send_frame(0, 8'h81, 0, 0, 1, 0);
        check_errs(0, "after_reset");

        // Randomized frames on both receivers
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            sg  = ($urandom_range(0, 4) != 0);
            pg  = (sel == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            xl  = sg ? 0 : int'($urandom_range(0, 2));
            model_frame(sel, d, pg, sg, 0);
            send_frame(sel, d, sel == 1, even_par(d) ^ !pg, sg, xl);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

        // Drain, bounded
        for (int i = 0; i < 200 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(posedge clk);
        #1;
        check("drain_queues", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        check_errs(0, "final_dut0");
        check_errs(1, "final_dut1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
